// File: rtl/endec_pkg.sv
// Shared encoder/decoder definitions: limits, code-rate and constraint-length codes,
// the encoder state type and the constraint-length decode helper.
package endec_pkg;

   localparam int MAX_CONSTRAINT_LENGTH = 9;
   localparam int MAX_CODE_RATE         = 3;

   localparam logic CODE_RATE_2 = 1'b0;
   localparam logic CODE_RATE_3 = 1'b1;

   localparam logic [1:0] CONSTR_LEN_3 = 2'd0;
   localparam logic [1:0] CONSTR_LEN_5 = 2'd1;
   localparam logic [1:0] CONSTR_LEN_7 = 2'd2;
   localparam logic [1:0] CONSTR_LEN_9 = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DATA  = 2'd1,
      ST_TAIL  = 2'd2,
      ST_FLUSH = 2'd3
   } enc_state_t;

   // code 0..3 maps to K = 3,5,7,9
   function automatic logic [3:0] constr_len_to_k(input logic [1:0] cl);
      return {1'b0, cl, 1'b1} + 4'd2;
   endfunction

endpackage

// File: rtl/conv_sym_gen.sv
// Combinational parity generator: one parity bit per polynomial over the
// K-bit window; taps at or above K and polynomials beyond the rate are zero.
module conv_sym_gen
   import endec_pkg::*;
#(
   parameter int MAX_K = MAX_CONSTRAINT_LENGTH,
   parameter int MAX_N = MAX_CODE_RATE
) (
   input  logic [MAX_K-1:0]            i_win,
   input  logic [MAX_N-1:0][MAX_K-1:0] i_poly,
   input  logic [3:0]                  i_k,
   input  logic                        i_code_rate,
   output logic [MAX_N-1:0]            o_sym
);

   logic [MAX_K-1:0] w_kmask;

   always_comb begin
      w_kmask = '0;
      for (int i = 0; i < MAX_K; i++) begin
         w_kmask[i] = (i < int'(i_k));
      end
   end

   always_comb begin
      o_sym = '0;
      for (int j = 0; j < MAX_N; j++) begin
         if ((j < 2) || (j == 2 && i_code_rate == CODE_RATE_3)) begin
            o_sym[j] = ^(i_poly[j] & w_kmask & i_win);
         end
      end
   end

endmodule

// File: rtl/conv_encoder_frame.sv
// Framed streaming convolutional encoder with zero-tail termination and a
// one-entry output register. Optional puncturing is enabled by PUNCTURE_EN.
//
// state    | meaning
// ST_IDLE  | waiting for i_start, config latched on start
// ST_DATA  | accepting info bits from upstream
// ST_TAIL  | injecting K-1 zero bits to terminate the trellis
// ST_FLUSH | waiting for downstream to take the last tail symbol
module conv_encoder_frame
   import endec_pkg::*;
#(
   parameter int MAX_K  = MAX_CONSTRAINT_LENGTH,
   parameter int MAX_N  = MAX_CODE_RATE,
   parameter int FLEN_W = 12
) (
   input  logic                        sys_clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic                        i_code_rate,
   input  logic [1:0]                  i_constr_len,
   input  logic [MAX_N-1:0][MAX_K-1:0] i_gen_poly,
   input  logic [FLEN_W-1:0]           i_frame_len,
`ifdef PUNCTURE_EN
   input  logic [2*MAX_N-1:0]          i_punct_pat,
`endif
   input  logic                        i_start,
   input  logic                        i_bit,
   input  logic                        i_bit_valid,
   output logic                        o_bit_ready,
   output logic [MAX_N-1:0]            o_sym,
   output logic [MAX_N-1:0]            o_sym_mask,
   output logic                        o_sym_valid,
   input  logic                        i_sym_ready,
   output logic                        o_busy,
   output logic                        o_frame_done,
   output logic                        o_err
);

   enc_state_t                  r_state, w_state_nxt;
   logic [MAX_K-2:0]            r_shift;
   logic [FLEN_W-1:0]           r_cnt;
   logic [3:0]                  r_tail_cnt;
   logic                        r_code_rate;
   logic [1:0]                  r_constr_len;
   logic [MAX_N-1:0][MAX_K-1:0] r_gen_poly;
   logic [MAX_N-1:0]            r_sym, r_mask;
   logic                        r_sym_valid;

   logic             w_slot, w_adv, w_sym_hs, w_start, w_in_bit;
   logic             w_last_bit, w_last_tail;
   logic [3:0]       w_k;
   logic [MAX_K-1:0] w_win;
   logic [MAX_N-1:0] w_par, w_base_mask, w_mask;

   assign w_slot      = !r_sym_valid || i_sym_ready;
   assign w_sym_hs    = en && r_sym_valid && i_sym_ready;
   assign w_adv       = en && w_slot &&
                        ((r_state == ST_DATA && i_bit_valid) || r_state == ST_TAIL);
   assign w_start     = en && (r_state == ST_IDLE) && i_start && (i_frame_len != '0);
   assign w_in_bit    = (r_state == ST_DATA) && i_bit;
   assign w_last_bit  = (r_cnt == FLEN_W'(1));
   assign w_last_tail = (r_tail_cnt == 4'd1);
   assign w_k         = constr_len_to_k(r_constr_len);
   assign w_win       = {r_shift, w_in_bit};

   conv_sym_gen #(
      .MAX_K (MAX_K),
      .MAX_N (MAX_N)
   ) u_sym_gen (
      .i_win       (w_win),
      .i_poly      (r_gen_poly),
      .i_k         (w_k),
      .i_code_rate (r_code_rate),
      .o_sym       (w_par)
   );

   always_comb begin
      w_base_mask = '0;
      for (int j = 0; j < MAX_N; j++) begin
         w_base_mask[j] = (j < 2) || (j == 2 && r_code_rate == CODE_RATE_3);
      end
   end

`ifdef PUNCTURE_EN
   logic               r_phase;
   logic [2*MAX_N-1:0] r_punct_pat;

   assign w_mask = w_base_mask &
                   (r_phase ? r_punct_pat[2*MAX_N-1:MAX_N] : r_punct_pat[MAX_N-1:0]);

   // phase advances once per emitted symbol, data and tail alike
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         r_phase     <= 1'b0;
         r_punct_pat <= '0;
      end else if (w_start) begin
         r_phase     <= 1'b0;
         r_punct_pat <= i_punct_pat;
      end else if (w_adv) begin
         r_phase     <= ~r_phase;
      end
   end
`else
   assign w_mask = w_base_mask;
`endif

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_start)                  w_state_nxt = ST_DATA;
         ST_DATA:  if (w_adv && w_last_bit)      w_state_nxt = ST_TAIL;
         ST_TAIL:  if (w_adv && w_last_tail)     w_state_nxt = ST_FLUSH;
         ST_FLUSH: if (w_sym_hs)                 w_state_nxt = ST_IDLE;
         default:                                w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         r_shift      <= '0;
         r_cnt        <= '0;
         r_tail_cnt   <= '0;
         r_code_rate  <= 1'b0;
         r_constr_len <= '0;
         r_gen_poly   <= '0;
         r_sym        <= '0;
         r_mask       <= '0;
         r_sym_valid  <= 1'b0;
      end else if (en) begin
         if (w_start) begin
            r_code_rate  <= i_code_rate;
            r_constr_len <= i_constr_len;
            r_gen_poly   <= i_gen_poly;
            r_cnt        <= i_frame_len;
            r_tail_cnt   <= '0;
            r_shift      <= '0;
         end
         if (w_adv) begin
            r_shift     <= w_win[MAX_K-2:0];
            r_sym       <= w_par & w_mask;
            r_mask      <= w_mask;
            r_sym_valid <= 1'b1;
            if (r_state == ST_DATA) begin
               r_cnt <= r_cnt - FLEN_W'(1);
               if (w_last_bit) r_tail_cnt <= w_k - 4'd1;
            end else begin
               r_tail_cnt <= r_tail_cnt - 4'd1;
            end
         end else if (w_sym_hs) begin
            r_sym_valid <= 1'b0;
         end
         // bits above K-1 may hold stale data; clear the whole register at frame end
         if (r_state == ST_FLUSH && w_sym_hs) begin
            r_shift <= '0;
         end
      end
   end

   assign o_bit_ready  = en && (r_state == ST_DATA) && w_slot;
   assign o_sym        = r_sym;
   assign o_sym_mask   = r_mask;
   assign o_sym_valid  = r_sym_valid;
   assign o_busy       = (r_state != ST_IDLE);
   assign o_frame_done = (r_state == ST_FLUSH) && w_sym_hs;
   assign o_err        = en && (r_state == ST_IDLE) && i_start && (i_frame_len == '0);

endmodule

// File: tb/tb_conv_encoder_frame.sv
// Directed bench for conv_encoder_frame; puncturing test builds with PUNCTURE_EN.
module tb_conv_encoder_frame;
   import endec_pkg::*;

   logic             sys_clk = 1'b0;
   logic             rst = 1'b1;
   logic             en = 1'b1;
   logic             i_code_rate = 1'b0;
   logic [1:0]       i_constr_len = 2'd0;
   logic [2:0][8:0]  i_gen_poly = '0;
   logic [11:0]      i_frame_len = '0;
`ifdef PUNCTURE_EN
   logic [5:0]       i_punct_pat = 6'b111_111;
`endif
   logic             i_start = 1'b0;
   logic             i_bit = 1'b0;
   logic             i_bit_valid = 1'b0;
   logic             o_bit_ready;
   logic [2:0]       o_sym, o_sym_mask;
   logic             o_sym_valid;
   logic             i_sym_ready = 1'b1;
   logic             o_busy, o_frame_done, o_err;

   int n_total = 0;
   int n_bad   = 0;
   logic [2:0] exp_sym[16];
   logic [2:0] exp_mask[16];

   always #5 sys_clk = ~sys_clk;

   conv_encoder_frame dut (
      .sys_clk      (sys_clk),
      .rst          (rst),
      .en           (en),
      .i_code_rate  (i_code_rate),
      .i_constr_len (i_constr_len),
      .i_gen_poly   (i_gen_poly),
      .i_frame_len  (i_frame_len),
`ifdef PUNCTURE_EN
      .i_punct_pat  (i_punct_pat),
`endif
      .i_start      (i_start),
      .i_bit        (i_bit),
      .i_bit_valid  (i_bit_valid),
      .o_bit_ready  (o_bit_ready),
      .o_sym        (o_sym),
      .o_sym_mask   (o_sym_mask),
      .o_sym_valid  (o_sym_valid),
      .i_sym_ready  (i_sym_ready),
      .o_busy       (o_busy),
      .o_frame_done (o_frame_done),
      .o_err        (o_err)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_frame(input string nm, input logic rate, input logic [1:0] cl,
                            input int len, input logic [15:0] bits, input int nexp,
                            input int stall_at, input int stall_n);
      int bi, si, stall_left, cyc;
      @(negedge sys_clk);
      i_code_rate  = rate;
      i_constr_len = cl;
      i_frame_len  = 12'(len);
      i_start      = 1'b1;
      @(negedge sys_clk);
      i_start = 1'b0;
      bi = 0; si = 0; stall_left = -1; cyc = 0;
      while (si < nexp && cyc < 200) begin
         if (si == stall_at && stall_left < 0) stall_left = stall_n;
         i_sym_ready = (stall_left > 0) ? 1'b0 : 1'b1;
         i_bit_valid = (bi < len);
         i_bit       = (bi < len) ? bits[bi] : 1'b0;
         #1;
         if (stall_left > 0) begin
            check_val({nm, " stall valid"}, o_sym_valid, 1);
            check_val({nm, " stall sym"}, o_sym, exp_sym[si]);
            check_val({nm, " stall ready"}, o_bit_ready, 0);
            stall_left--;
         end
         if (o_sym_valid && i_sym_ready) begin
            check_val($sformatf("%s sym%0d", nm, si), o_sym, exp_sym[si]);
            check_val($sformatf("%s mask%0d", nm, si), o_sym_mask, exp_mask[si]);
            check_val($sformatf("%s done%0d", nm, si), o_frame_done, (si == nexp - 1));
            si++;
         end
         if (o_bit_ready && i_bit_valid) bi++;
         @(negedge sys_clk);
         cyc++;
      end
      if (si < nexp) check_val({nm, " timeout"}, si, nexp);
      check_val({nm, " bits used"}, bi, len);
      i_bit_valid = 1'b0;
      #1;
      check_val({nm, " busy end"}, o_busy, 0);
      check_val({nm, " done end"}, o_frame_done, 0);
   endtask

   task automatic load_t1;
      i_gen_poly[0] = 9'b000000111;
      i_gen_poly[1] = 9'b000000101;
      i_gen_poly[2] = 9'b000000111;
      exp_sym  = '{0:3'd3, 1:3'd2, 2:3'd2, 3:3'd0, 4:3'd1, 5:3'd3, 6:3'd3, 7:3'd1,
                   8:3'd3, 9:3'd0, default:3'd0};
      exp_mask = '{default:3'b011};
   endtask

   initial begin
      repeat (3) @(negedge sys_clk);
      #1;
      check_val("rst busy", o_busy, 0);
      check_val("rst valid", o_sym_valid, 0);
      check_val("rst sym", o_sym, 0);
      check_val("rst mask", o_sym_mask, 0);
      check_val("rst bit_ready", o_bit_ready, 0);
      check_val("rst done", o_frame_done, 0);
      check_val("rst err", o_err, 0);
      rst = 1'b0;

      // 1: rate 1/2, K=3, 111/101, data 11010010
      load_t1();
      run_frame("t1", CODE_RATE_2, CONSTR_LEN_3, 8, 16'h004B, 10, -1, 0);

      // 2: same with 3 cycles of downstream stall before symbol 2
      run_frame("t2", CODE_RATE_2, CONSTR_LEN_3, 8, 16'h004B, 10, 2, 3);

      // 3: rate 1/3, K=3, 111/101/011, single bit 1
      i_gen_poly[0] = 9'b000000111;
      i_gen_poly[1] = 9'b000000101;
      i_gen_poly[2] = 9'b000000011;
      exp_sym  = '{0:3'b111, 1:3'b101, 2:3'b011, default:3'd0};
      exp_mask = '{default:3'b111};
      run_frame("t3", CODE_RATE_3, CONSTR_LEN_3, 1, 16'h0001, 3, -1, 0);

      // 4: K=5, taps above K must be ignored; data 1,0,1,1
      i_gen_poly[0] = 9'b111110011;
      i_gen_poly[1] = 9'b000011101;
      i_gen_poly[2] = 9'b0;
      exp_sym  = '{0:3'd3, 1:3'd1, 2:3'd1, 3:3'd0, 4:3'd0, 5:3'd0, 6:3'd1, 7:3'd3,
                   default:3'd0};
      exp_mask = '{default:3'b011};
      run_frame("t4a", CODE_RATE_2, CONSTR_LEN_5, 4, 16'h000D, 8, -1, 0);
      i_gen_poly[0] = 9'b000010011;
      run_frame("t4b", CODE_RATE_2, CONSTR_LEN_5, 4, 16'h000D, 8, -1, 0);

      // 5: zero-length start, then reset mid-frame and rerun test 1
      @(negedge sys_clk);
      i_frame_len = '0;
      i_start     = 1'b1;
      #1;
      check_val("t5 err pulse", o_err, 1);
      check_val("t5 err busy", o_busy, 0);
      @(negedge sys_clk);
      i_start = 1'b0;
      #1;
      check_val("t5 err clear", o_err, 0);
      check_val("t5 idle", o_busy, 0);

      load_t1();
      i_code_rate  = CODE_RATE_2;
      i_constr_len = CONSTR_LEN_3;
      i_frame_len  = 12'd8;
      i_start      = 1'b1;
      @(negedge sys_clk);
      i_start     = 1'b0;
      i_sym_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         i_bit_valid = 1'b1;
         i_bit       = (i != 2);
         @(negedge sys_clk);
      end
      #1;
      check_val("t5 midframe busy", o_busy, 1);
      rst         = 1'b1;
      i_bit_valid = 1'b0;
      @(negedge sys_clk);
      rst = 1'b0;
      #1;
      check_val("t5 rst busy", o_busy, 0);
      check_val("t5 rst valid", o_sym_valid, 0);
      check_val("t5 rst sym", o_sym, 0);
      check_val("t5 rst mask", o_sym_mask, 0);
      check_val("t5 rst ready", o_bit_ready, 0);
      run_frame("t5 rerun", CODE_RATE_2, CONSTR_LEN_3, 8, 16'h004B, 10, -1, 0);

`ifdef PUNCTURE_EN
      // 6: puncture pattern 001_011 on test 1 stream
      load_t1();
      i_punct_pat = 6'b001_011;
      exp_sym  = '{0:3'd3, 1:3'd0, 2:3'd2, 3:3'd0, 4:3'd1, 5:3'd1, 6:3'd3, 7:3'd1,
                   8:3'd3, 9:3'd0, default:3'd0};
      exp_mask = '{0:3'b011, 1:3'b001, 2:3'b011, 3:3'b001, 4:3'b011, 5:3'b001,
                   6:3'b011, 7:3'b001, 8:3'b011, 9:3'b001, default:3'd0};
      run_frame("t6", CODE_RATE_2, CONSTR_LEN_3, 8, 16'h004B, 10, -1, 0);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
